// File: rtl/ring_router_gateway_nring_pkg.sv
// Shared flit type, route/demux enums and the route-decision helper for the N-ring gateway.
package ring_router_gateway_nring_pkg;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

   typedef enum logic [1:0] {
      ROUTE_LOCAL,
      ROUTE_EXT,
      ROUTE_FWD
   } route_e;

   typedef enum logic {
      DMX_IDLE,
      DMX_LOCKED
   } dmx_state_e;

   // Injection mux input order also sets its round-robin order.
   localparam int unsigned INJ_PORTS = 3;
   localparam int unsigned INJ_FWD   = 0;
   localparam int unsigned INJ_LOCAL = 1;
   localparam int unsigned INJ_EXT   = 2;

   function automatic route_e route_of(input logic [15:0] dest,
                                       input logic [15:0] id,
                                       input logic        off_subnet,
                                       input logic        ext_en);
      if (dest == id)
         return ROUTE_LOCAL;
      else if (off_subnet && ext_en)
         return ROUTE_EXT;
      else
         return ROUTE_FWD;
   endfunction

endpackage

// File: rtl/dii_buffer.sv
// Flit FIFO for one ring output; registered storage gives at least one cycle of latency.
module dii_buffer
   import ring_router_gateway_nring_pkg::*;
#(
   parameter int unsigned BUF_SIZE = 4
)(
   input  logic    clk,
   input  logic    rst,
   input  dii_flit flit_in,
   output logic    flit_in_ready,
   output dii_flit flit_out,
   input  logic    flit_out_ready
);

   localparam int unsigned PW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
   localparam int unsigned CW = $clog2(BUF_SIZE + 1);

   logic [BUF_SIZE-1:0][16:0] r_mem;
   logic [PW-1:0]             r_wr;
   logic [PW-1:0]             r_rd;
   logic [CW-1:0]             r_cnt;
   logic                      w_push;
   logic                      w_pop;

   // Readiness ignores a same-cycle pop, so a full FIFO always stalls the writer one cycle.
   assign flit_in_ready = !rst && (r_cnt != CW'(BUF_SIZE));
   assign flit_out      = '{valid: (r_cnt != '0), last: r_mem[r_rd][16], data: r_mem[r_rd][15:0]};
   assign w_push        = flit_in.valid && flit_in_ready;
   assign w_pop         = flit_out.valid && flit_out_ready;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr] <= {flit_in.last, flit_in.data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push)
            r_wr <= (r_wr == PW'(BUF_SIZE - 1)) ? '0 : r_wr + 1'b1;
         if (w_pop)
            r_rd <= (r_rd == PW'(BUF_SIZE - 1)) ? '0 : r_rd + 1'b1;
         if (w_push && !w_pop)
            r_cnt <= r_cnt + 1'b1;
         else if (!w_push && w_pop)
            r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/ring_router_mux_rr_n.sv
// N-input packet round-robin arbiter: a grant is held for a whole packet, then priority moves past the winner.
module ring_router_mux_rr_n
   import ring_router_gateway_nring_pkg::*;
#(
   parameter int unsigned N = 3
)(
   input  logic              clk,
   input  logic              rst,
   input  dii_flit [N-1:0]   in_flit,
   output logic    [N-1:0]   in_ready,
   output dii_flit           out_flit,
   input  logic              out_ready
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic          r_locked;
   logic [IW-1:0] r_owner;
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_grant;
   logic          w_any;
   logic          w_xfer;

   always_comb begin
      w_grant = r_owner;
      w_any   = 1'b0;
      if (r_locked) begin
         w_any = in_flit[r_owner].valid;
      end else begin
         for (int unsigned k = 0; k < N; k++) begin
            if (!w_any && in_flit[IW'((32'(r_ptr) + k) % N)].valid) begin
               w_any   = 1'b1;
               w_grant = IW'((32'(r_ptr) + k) % N);
            end
         end
      end
   end

   always_comb begin
      out_flit           = in_flit[w_grant];
      out_flit.valid     = w_any && !rst;
      in_ready           = '0;
      in_ready[w_grant]  = out_ready && w_any && !rst;
   end

   assign w_xfer = out_flit.valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_locked <= 1'b0;
         r_owner  <= '0;
         r_ptr    <= '0;
      end else if (w_xfer) begin
         if (out_flit.last) begin
            r_locked <= 1'b0;
            r_ptr    <= (w_grant == IW'(N - 1)) ? '0 : w_grant + 1'b1;
         end else begin
            r_locked <= 1'b1;
            r_owner  <= w_grant;
         end
      end
   end

endmodule

// File: rtl/ring_router_gateway_nring.sv
// Gateway router for NUM_RINGS rings: per-ring packet demux to local/ext/forward, RR ejection muxes,
// injection onto one ring, and a FIFO on every ring output.
module ring_router_gateway_nring
   import ring_router_gateway_nring_pkg::*;
#(
   parameter int unsigned NUM_RINGS    = 3,
   parameter int unsigned BUFFER_SIZE  = 4,
   parameter int unsigned SUBNET_BITS  = 6,
   parameter int unsigned LOCAL_SUBNET = 0,
   parameter int unsigned INJECT_RING  = 0,
   parameter int unsigned EXT_ENABLE   = 1
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic    [15:0]           id,
   input  dii_flit [NUM_RINGS-1:0]  ring_in,
   output logic    [NUM_RINGS-1:0]  ring_in_ready,
   output dii_flit [NUM_RINGS-1:0]  ring_out,
   input  logic    [NUM_RINGS-1:0]  ring_out_ready,
   input  dii_flit                  local_in,
   output logic                     local_in_ready,
   output dii_flit                  local_out,
   input  logic                     local_out_ready,
   input  dii_flit                  ext_in,
   output logic                     ext_in_ready,
   output dii_flit                  ext_out,
   input  logic                     ext_out_ready
);

   dii_flit [NUM_RINGS-1:0] w_to_local;
   dii_flit [NUM_RINGS-1:0] w_to_ext;
   dii_flit [NUM_RINGS-1:0] w_to_fwd;
   logic    [NUM_RINGS-1:0] w_local_rdy;
   logic    [NUM_RINGS-1:0] w_ext_rdy;
   logic    [NUM_RINGS-1:0] w_fwd_rdy;
   dii_flit [NUM_RINGS-1:0] w_buf_in;
   logic    [NUM_RINGS-1:0] w_buf_in_rdy;

   for (genvar i = 0; i < NUM_RINGS; i++) begin : g_ring
      dmx_state_e r_state;
      route_e     r_target;
      route_e     w_route;
      route_e     w_sel;
      logic       w_off_subnet;

      assign w_off_subnet = ring_in[i].data[15 -: SUBNET_BITS] != SUBNET_BITS'(LOCAL_SUBNET);
      assign w_route      = route_of(ring_in[i].data, id, w_off_subnet, EXT_ENABLE != 0);
      assign w_sel        = (r_state == DMX_LOCKED) ? r_target : w_route;

      assign w_to_local[i] = '{valid: ring_in[i].valid && (w_sel == ROUTE_LOCAL),
                               last: ring_in[i].last, data: ring_in[i].data};
      assign w_to_ext[i]   = '{valid: ring_in[i].valid && (w_sel == ROUTE_EXT),
                               last: ring_in[i].last, data: ring_in[i].data};
      assign w_to_fwd[i]   = '{valid: ring_in[i].valid && (w_sel == ROUTE_FWD),
                               last: ring_in[i].last, data: ring_in[i].data};

      assign ring_in_ready[i] = (w_sel == ROUTE_LOCAL) ? w_local_rdy[i] :
                                (w_sel == ROUTE_EXT)   ? w_ext_rdy[i]   : w_fwd_rdy[i];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_state  <= DMX_IDLE;
            r_target <= ROUTE_FWD;
         end else if (ring_in[i].valid && ring_in_ready[i]) begin
            if (r_state == DMX_IDLE && !ring_in[i].last) begin
               r_state  <= DMX_LOCKED;
               r_target <= w_route;
            end else if (r_state == DMX_LOCKED && ring_in[i].last) begin
               r_state  <= DMX_IDLE;
            end
         end
      end

      if (i == INJECT_RING) begin : g_inj
         dii_flit [INJ_PORTS-1:0] w_inj_in;
         logic    [INJ_PORTS-1:0] w_inj_rdy;

         assign w_inj_in = {ext_in, local_in, w_to_fwd[i]};

         ring_router_mux_rr_n #(.N(INJ_PORTS)) u_inj_mux (
            .clk       (clk),
            .rst       (rst),
            .in_flit   (w_inj_in),
            .in_ready  (w_inj_rdy),
            .out_flit  (w_buf_in[i]),
            .out_ready (w_buf_in_rdy[i])
         );

         assign w_fwd_rdy[i]   = w_inj_rdy[INJ_FWD];
         assign local_in_ready = w_inj_rdy[INJ_LOCAL];
         assign ext_in_ready   = w_inj_rdy[INJ_EXT];
      end else begin : g_fwd
         assign w_buf_in[i]  = w_to_fwd[i];
         assign w_fwd_rdy[i] = w_buf_in_rdy[i];
      end

      dii_buffer #(.BUF_SIZE(BUFFER_SIZE)) u_buf (
         .clk            (clk),
         .rst            (rst),
         .flit_in        (w_buf_in[i]),
         .flit_in_ready  (w_buf_in_rdy[i]),
         .flit_out       (ring_out[i]),
         .flit_out_ready (ring_out_ready[i])
      );
   end

   ring_router_mux_rr_n #(.N(NUM_RINGS)) u_local_mux (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (w_to_local),
      .in_ready  (w_local_rdy),
      .out_flit  (local_out),
      .out_ready (local_out_ready)
   );

   ring_router_mux_rr_n #(.N(NUM_RINGS)) u_ext_mux (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (w_to_ext),
      .in_ready  (w_ext_rdy),
      .out_flit  (ext_out),
      .out_ready (ext_out_ready)
   );

endmodule

// File: tb/tb_ring_router_gateway_nring.sv
// Directed bench for the N-ring gateway: routing table vectors plus arbitration, backpressure and reset sequences.
module tb_ring_router_gateway_nring;
   import ring_router_gateway_nring_pkg::*;

   localparam int unsigned NR = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [15:0]       id;
   dii_flit [NR-1:0]  ring_in;
   logic    [NR-1:0]  ring_in_ready, nx_ring_in_ready;
   dii_flit [NR-1:0]  ring_out, nx_ring_out;
   logic    [NR-1:0]  ring_out_ready;
   dii_flit           local_in, local_out, ext_in, ext_out, nx_local_out, nx_ext_out;
   logic              local_in_ready, local_out_ready, ext_in_ready, ext_out_ready;
   logic              nx_local_in_ready, nx_ext_in_ready;

   ring_router_gateway_nring #(
      .NUM_RINGS(NR), .BUFFER_SIZE(4), .SUBNET_BITS(6), .LOCAL_SUBNET(0),
      .INJECT_RING(0), .EXT_ENABLE(1)
   ) dut (
      .clk(clk), .rst(rst), .id(id),
      .ring_in(ring_in), .ring_in_ready(ring_in_ready),
      .ring_out(ring_out), .ring_out_ready(ring_out_ready),
      .local_in(local_in), .local_in_ready(local_in_ready),
      .local_out(local_out), .local_out_ready(local_out_ready),
      .ext_in(ext_in), .ext_in_ready(ext_in_ready),
      .ext_out(ext_out), .ext_out_ready(ext_out_ready)
   );

   // Same stimulus, external port disabled: off-subnet packets must be forwarded instead.
   ring_router_gateway_nring #(
      .NUM_RINGS(NR), .BUFFER_SIZE(4), .SUBNET_BITS(6), .LOCAL_SUBNET(0),
      .INJECT_RING(0), .EXT_ENABLE(0)
   ) dut_nx (
      .clk(clk), .rst(rst), .id(id),
      .ring_in(ring_in), .ring_in_ready(nx_ring_in_ready),
      .ring_out(nx_ring_out), .ring_out_ready(ring_out_ready),
      .local_in(local_in), .local_in_ready(nx_local_in_ready),
      .local_out(nx_local_out), .local_out_ready(local_out_ready),
      .ext_in(ext_in), .ext_in_ready(nx_ext_in_ready),
      .ext_out(nx_ext_out), .ext_out_ready(ext_out_ready)
   );

   // Observed port numbers: 0-2 ring_out, 3 local, 4 ext; 5-9 the same for dut_nx.
   typedef struct packed {
      logic [3:0]  port;
      logic        last;
      logic [15:0] data;
   } obs_t;
   obs_t obs_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < int'(NR); p++) begin
            if (ring_out[p].valid && ring_out_ready[p])
               obs_q.push_back({4'(p), ring_out[p].last, ring_out[p].data});
            if (nx_ring_out[p].valid && ring_out_ready[p])
               obs_q.push_back({4'(p + 5), nx_ring_out[p].last, nx_ring_out[p].data});
         end
         if (local_out.valid && local_out_ready)
            obs_q.push_back({4'd3, local_out.last, local_out.data});
         if (ext_out.valid && ext_out_ready)
            obs_q.push_back({4'd4, ext_out.last, ext_out.data});
         if (nx_local_out.valid && local_out_ready)
            obs_q.push_back({4'd8, nx_local_out.last, nx_local_out.data});
         if (nx_ext_out.valid && ext_out_ready)
            obs_q.push_back({4'd9, nx_ext_out.last, nx_ext_out.data});
      end
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   function automatic int cnt_port(input int p);
      int c;
      c = 0;
      foreach (obs_q[j]) if (obs_q[j].port == 4'(p)) c++;
      return c;
   endfunction

   function automatic logic [16:0] get_port(input int p, input int idx);
      int c;
      c = 0;
      foreach (obs_q[j]) begin
         if (obs_q[j].port == 4'(p)) begin
            if (c == idx) return {obs_q[j].last, obs_q[j].data};
            c++;
         end
      end
      return 17'h1FFFF;
   endfunction

   function automatic logic [15:0] pay(input int ch, input int k);
      return 16'hA000 | 16'(ch * 256) | 16'(k);
   endfunction

   task automatic check_seq(input string name, input int p, input logic [16:0] exp[$]);
      chk({name, " count"}, cnt_port(p), exp.size());
      foreach (exp[j]) chk($sformatf("%s flit%0d", name, j), 32'(get_port(p, j)), 32'(exp[j]));
   endtask

   // Channels: 0-2 ring_in, 3 local_in, 4 ext_in.
   task automatic drive(input int ch, input logic v, input logic l, input logic [15:0] d);
      case (ch)
         0, 1, 2: ring_in[ch[1:0]] = {v, l, d};
         3:       local_in = {v, l, d};
         default: ext_in = {v, l, d};
      endcase
   endtask

   function automatic logic rdy(input int ch);
      case (ch)
         0, 1, 2: return ring_in_ready[ch[1:0]];
         3:       return local_in_ready;
         default: return ext_in_ready;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input logic [15:0] dest, input int n);
      logic acc;
      int   t;
      for (int k = 0; k < n; k++) begin
         drive(ch, 1'b1, k == n - 1, (k == 0) ? dest : pay(ch, k));
         acc = 1'b0;
         t   = 0;
         while (!acc && t < 300) begin
            @(negedge clk);
            acc = rdy(ch);
            if (!acc) begin @(posedge clk); #1; end
            t++;
         end
         if (!acc) begin
            fail_now($sformatf("send ch%0d flit%0d", ch, k));
            drive(ch, 1'b0, 1'b0, 16'h0);
            return;
         end
         @(posedge clk); #1;
      end
      drive(ch, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      ring_in = '0; local_in = '0; ext_in = '0;
      ring_out_ready = '1; local_out_ready = 1'b1; ext_out_ready = 1'b1;
      tick(2);
      rst = 1'b0;
      obs_q.delete();
      tick(1);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({ring_out[2].valid, ring_out[1].valid, ring_out[0].valid, local_out.valid, ext_out.valid,
                  ring_in_ready, local_in_ready, ext_in_ready,
                  nx_ring_out[2].valid, nx_ring_out[1].valid, nx_ring_out[0].valid,
                  nx_local_out.valid, nx_ext_out.valid});
   endfunction

   typedef struct packed {
      logic [1:0]  ring;
      logic [15:0] dest;
      logic [3:0]  port;
      logic [3:0]  port_nx;
   } vec_t;
   vec_t vt[9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [16:0] exp[$];
      int          bad;
      int          t;

      // {ring, dest, port with ext enabled, port with ext disabled}
      vt[0] = '{2'd1, 16'h0005, 4'd3, 4'd8};
      vt[1] = '{2'd2, 16'h0405, 4'd4, 4'd7};
      vt[2] = '{2'd0, 16'h0006, 4'd0, 4'd5};
      vt[3] = '{2'd1, 16'h0006, 4'd1, 4'd6};
      vt[4] = '{2'd2, 16'hFC05, 4'd4, 4'd7};
      vt[5] = '{2'd0, 16'h0005, 4'd3, 4'd8};
      vt[6] = '{2'd2, 16'h03FF, 4'd2, 4'd7};
      vt[7] = '{2'd1, 16'h0400, 4'd4, 4'd6};
      vt[8] = '{2'd0, 16'h0405, 4'd4, 4'd5};

      rst = 1'b1; id = 16'h0005;
      ring_in = '0; local_in = '0; ext_in = '0;
      ring_out_ready = '1; local_out_ready = 1'b1; ext_out_ready = 1'b1;
      local_in = '{valid: 1'b1, last: 1'b1, data: 16'h0005};
      ring_in[1] = '{valid: 1'b1, last: 1'b1, data: 16'h0005};
      tick(3);
      chk("reset outputs idle", all_outs(), 32'h0);
      do_reset();

      for (int v = 0; v < 9; v++) begin
         send(int'(vt[v].ring), vt[v].dest, 1);
         tick(3);
         chk($sformatf("vec%0d port count", v), cnt_port(int'(vt[v].port)), 1);
         chk($sformatf("vec%0d port flit", v), 32'(get_port(int'(vt[v].port), 0)), 32'({1'b1, vt[v].dest}));
         chk($sformatf("vec%0d noext flit", v), 32'(get_port(int'(vt[v].port_nx), 0)), 32'({1'b1, vt[v].dest}));
         chk($sformatf("vec%0d total seen", v), obs_q.size(), 2);
         obs_q.delete();
      end

      do_reset();
      send(1, 16'h0005, 2);
      tick(3);
      exp = '{{1'b0, 16'h0005}, {1'b1, pay(1, 1)}};
      check_seq("local 2-flit", 3, exp);
      chk("local 2-flit ring_out1 empty", cnt_port(1), 0);

      do_reset();
      fork
         send(0, 16'h0005, 3);
         send(1, 16'h0005, 3);
         send(2, 16'h0005, 3);
      join
      tick(3);
      exp.delete();
      for (int s = 0; s < 3; s++)
         for (int k = 0; k < 3; k++)
            exp.push_back({k == 2, (k == 0) ? 16'h0005 : pay(s, k)});
      check_seq("rr local", 3, exp);

      do_reset();
      fork
         send(2, 16'h0005, 3);
         begin
            t = 0;
            @(negedge clk);
            while (!(local_out.valid && local_out_ready) && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) fail_now("bp first flit");
            @(posedge clk); #1;
            local_out_ready = 1'b0;
            bad = 0;
            repeat (10) begin
               @(negedge clk);
               if (ring_in_ready[2] !== 1'b0 || local_out.valid !== 1'b1) bad++;
            end
            chk("bp stall cycles with ready high", bad, 0);
            chk("bp local count during stall", cnt_port(3), 1);
            @(posedge clk); #1;
            local_out_ready = 1'b1;
         end
      join
      tick(3);
      exp = '{{1'b0, 16'h0005}, {1'b0, pay(2, 1)}, {1'b1, pay(2, 2)}};
      check_seq("bp local", 3, exp);

      do_reset();
      ring_out_ready[0] = 1'b0;
      fork
         send(0, 16'h0006, 2);
         send(3, 16'h0006, 2);
         send(4, 16'h0405, 2);
         begin
            tick(8);
            @(negedge clk);
            chk("inj readies when full", 32'({ring_in_ready[0], local_in_ready, ext_in_ready}), 32'h0);
            chk("inj ring_out0 valid when full", 32'(ring_out[0].valid), 32'h1);
            chk("inj nothing drained", cnt_port(0), 0);
            @(posedge clk); #1;
            ring_out_ready[0] = 1'b1;
         end
      join
      tick(6);
      exp = '{{1'b0, 16'h0006}, {1'b1, pay(0, 1)}, {1'b0, 16'h0006}, {1'b1, pay(3, 1)},
              {1'b0, 16'h0405}, {1'b1, pay(4, 1)}};
      check_seq("inj order", 0, exp);

      do_reset();
      ring_out_ready[1] = 1'b0;
      send(1, 16'h0006, 1);
      @(negedge clk);
      chk("rstmid fifo1 holds flit", 32'(ring_out[1].valid), 32'h1);
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b0, 16'h0405);
      @(negedge clk);
      chk("rstmid header to ext ready", 32'(ring_in_ready[1]), 32'h1);
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b0, 16'h0005);
      @(negedge clk);
      chk("rstmid locked body on ext", 32'({ext_out.valid, local_out.valid, ext_out.data}), 32'h20005);
      rst = 1'b1;
      #1;
      chk("rstmid outputs idle in reset", all_outs(), 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      obs_q.delete();
      ring_out_ready = '1;
      drive(1, 1'b1, 1'b1, 16'h0005);
      @(negedge clk);
      chk("rstmid new header ready", 32'(ring_in_ready[1]), 32'h1);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 16'h0);
      tick(3);
      exp = '{{1'b1, 16'h0005}};
      check_seq("rstmid local", 3, exp);
      chk("rstmid ext empty", cnt_port(4), 0);
      chk("rstmid fifo1 cleared", cnt_port(1), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
